// File: rtl/snn_inference_controller.sv
// snn_inference_controller: sequences spike frames into a network, counts output spikes and picks the winning class
module snn_inference_controller #(
    parameter int N_INPUTS     = 208,
    parameter int N_OUTPUTS    = 4,
    parameter int N_STEPS      = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 6,
    localparam int CLS_W       = N_OUTPUTS > 1 ? $clog2(N_OUTPUTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic [N_INPUTS-1:0]        frame_in,
    output logic [N_INPUTS-1:0]        net_inputs,
    input  logic [N_OUTPUTS-1:0]       net_outputs,
    output logic                       busy,
    output logic                       done,
    output logic [CLS_W-1:0]           class_out,
    output logic                       no_spike,
    output logic [CNT_W*N_OUTPUTS-1:0] spike_counts_flat
);
    localparam int SW = $clog2(N_STEPS + 1);
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [SW-1:0] LAST_STEP  = SW'(N_STEPS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DECIDE} state_t;

    state_t             state, state_n;
    logic [SW-1:0]      step;
    logic [DW-1:0]      dcnt;
    logic [CNT_W-1:0]   cnt [N_OUTPUTS];
    logic               accept, last_frame, counting, clear;
    logic [CLS_W-1:0]   best_idx;
    logic [CNT_W-1:0]   best_val;

    assign accept     = frame_valid & frame_ready;
    assign last_frame = accept && step == LAST_STEP;
    assign counting   = state == RUN || state == DRAIN;
    assign clear      = state == IDLE && start;

    // next state plus the state-decoded handshake and busy flags
    always_comb begin
        state_n     = state;
        frame_ready = state == RUN;
        busy        = state != IDLE;
        unique case (state)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN:     state_n = last_frame ? (DRAIN_CYCLES == 0 ? DECIDE : DRAIN) : RUN;
            DRAIN:   state_n = dcnt == LAST_DRAIN ? DECIDE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // argmax over counters; strict compare keeps the lowest index on ties
    always_comb begin
        best_idx = '0;
        best_val = cnt[0];
        for (int o = 1; o < N_OUTPUTS; o++)
            if (cnt[o] > best_val) begin
                best_val = cnt[o];
                best_idx = CLS_W'(o);
            end
    end

    // state, frame pipeline, step/drain counters, saturating spike counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            net_inputs <= '0;
            step       <= '0;
            dcnt       <= '0;
            class_out  <= '0;
            no_spike   <= 1'b0;
            done       <= 1'b0;
            for (int o = 0; o < N_OUTPUTS; o++) cnt[o] <= '0;
        end else begin
            state      <= state_n;
            done       <= state == DECIDE;
            net_inputs <= accept ? frame_in : '0;
            step       <= clear ? '0 : accept ? step + 1'b1 : step;
            dcnt       <= state == DRAIN ? dcnt + 1'b1 : '0;
            if (state == DECIDE) begin
                class_out <= best_idx;
                no_spike  <= best_val == '0;
            end
            for (int o = 0; o < N_OUTPUTS; o++)
                if (clear) cnt[o] <= '0;
                else if (counting && net_outputs[o] && cnt[o] != '1) cnt[o] <= cnt[o] + 1'b1;
        end
    end

    for (genvar g = 0; g < N_OUTPUTS; g++) begin : g_flat
        assign spike_counts_flat[g*CNT_W +: CNT_W] = cnt[g];
    end
endmodule

// File: doc/snn_inference_controller.md
SNN_INFERENCE_CONTROLLER -- requirements
Module: snn_inference_controller

Interface
REQ-001 SHALL have parameter N_INPUTS, default 208: spike-frame width, equal to the network input count.
REQ-002 SHALL have parameter N_OUTPUTS, default 4: number of output neurons observed.
REQ-003 SHALL have parameter N_STEPS, default 32: accepted frames per inference (>=1).
REQ-004 SHALL have parameter DRAIN_CYCLES, default 2: zero-input cycles after the last frame, covering network pipeline latency.
REQ-005 SHALL have parameter CNT_W, default 6: width of each output spike counter.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1: begin an inference; honoured only in IDLE.
REQ-009 SHALL have port frame_valid, input, 1: frame_in holds a valid spike frame.
REQ-010 SHALL have port frame_ready, output, 1: controller accepts a frame this cycle.
REQ-011 SHALL have port frame_in, input, N_INPUTS: input spike frame.
REQ-012 SHALL have port net_inputs, output, N_INPUTS: registered spikes driven to the network inputs.
REQ-013 SHALL have port net_outputs, input, N_OUTPUTS: network output spikes.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when the result becomes valid.
REQ-016 SHALL have port class_out, output, max(1,$clog2(N_OUTPUTS)): winning output index.
REQ-017 SHALL have port no_spike, output, 1: all counters zero at decision time.
REQ-018 SHALL have port spike_counts_flat, output, CNT_W*N_OUTPUTS: counter o occupies bits [o*CNT_W +: CNT_W].

Function
REQ-019 SHALL implement the states IDLE, RUN, DRAIN and DECIDE.
REQ-020 SHALL, in IDLE with start=1, clear all counters and the step counter and enter RUN on the next cycle; class_out and no_spike keep their previous values until DECIDE.
REQ-021 SHALL drive frame_ready=1 only in RUN, combinationally from state.
REQ-022 SHALL, in RUN, on frame_valid&frame_ready, register net_inputs<=frame_in and increment the step counter; on a cycle with no handshake, register net_inputs<=0 and hold the step counter (bubble).
REQ-023 SHALL leave RUN for DRAIN on the cycle that accepts frame number N_STEPS.
REQ-024 SHALL hold net_inputs at 0 in DRAIN, IDLE and DECIDE.
REQ-025 SHALL stay in DRAIN for exactly DRAIN_CYCLES cycles and then enter DECIDE; DRAIN_CYCLES=0 goes directly to DECIDE.
REQ-026 SHALL, on every cycle in RUN or DRAIN, increment counter o when net_outputs[o]=1, for all o in parallel.
REQ-027 SHALL saturate each counter at 2^CNT_W-1 with no wrap.
REQ-028 SHALL ignore net_outputs in IDLE and DECIDE.
REQ-029 SHALL, in DECIDE, register class_out as the index of the largest counter, with ties resolved to the lowest index.
REQ-030 SHALL, in DECIDE, register no_spike=1 when all counters are 0; class_out is then 0.
REQ-031 SHALL, in DECIDE, assert done for that single cycle and return to IDLE on the next cycle.
REQ-032 SHALL hold spike_counts_flat, class_out and no_spike stable in IDLE until the next start.
REQ-033 SHALL ignore start while busy=1.
REQ-034 SHALL take exactly 1+N_STEPS+DRAIN_CYCLES+1 cycles from start to done when frame_valid is held high.

Reset
REQ-035 SHALL, when rst=1 at a clock edge, enter IDLE and zero net_inputs, counters, step counter, class_out, no_spike, done and busy, with priority over all other inputs, including mid-inference.
REQ-036 SHALL, in the first cycle after rst deasserts, accept start normally.

Verification
REQ-037 SHALL pass this scenario: N_STEPS=4, DRAIN_CYCLES=2, frame_valid held 1, net_outputs=4'b0100 every cycle -> done 8 cycles after start, class_out=2, count[2]=6 (4 RUN + 2 DRAIN), others 0.
REQ-038 SHALL pass this scenario: frame_valid toggles 1,0,1,0... -> net_inputs=0 on bubble cycles; exactly N_STEPS frames are accepted; done is delayed by the number of bubbles.
REQ-039 SHALL pass this scenario: counts tie, with outputs 1 and 3 each spiking 3 times -> class_out=1.
REQ-040 SHALL pass this scenario: net_outputs=0 throughout -> no_spike=1, class_out=0, done pulses once.
REQ-041 SHALL pass this scenario: CNT_W=3, output 0 spikes for 12 counted cycles -> count[0]=7 and does not wrap.
REQ-042 SHALL pass this scenario: rst asserted mid-RUN together with start -> next cycle IDLE, all outputs 0, no done; a fresh start then completes normally.
